// File: rtl/memoria_frame_dupla_if.sv
// Bus bundle between the game/scanner side and the double-buffered frame memory.
// The master drives pixel writes, swap/wipe requests and the read row; the slave returns row data and status.
interface memoria_frame_dupla_if #(
  parameter int WIDTH = 16,
  parameter int X_W   = 4,
  parameter int Y_W   = 4
);
  logic [X_W-1:0]   coor_x;
  logic [Y_W-1:0]   coor_y;
  logic             we;
  logic [1:0]       op;
  logic             swap;
  logic             wipe;
  logic [Y_W-1:0]   rd_y;
  logic [WIDTH-1:0] saida_x;
  logic [Y_W-1:0]   saida_y;
  logic             busy;
  logic             front_sel;

  modport master (
    output coor_x, coor_y, we, op, swap, wipe, rd_y,
    input  saida_x, saida_y, busy, front_sel
  );

  modport slave (
    input  coor_x, coor_y, we, op, swap, wipe, rd_y,
    output saida_x, saida_y, busy, front_sel
  );
endinterface

// File: rtl/memoria_frame_dupla.sv
// Double-buffered LED-matrix frame memory: pixels are drawn into the back buffer while the
// scanner reads the front one; swaps exchange them and the new back buffer is wiped row by row.
module memoria_frame_dupla #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int X_W       = 4,
  parameter int Y_W       = 4,
  parameter bit AUTO_WIPE = 1'b1
) (
  input  logic                    clk,
  input  logic                    clear,
  memoria_frame_dupla_if.slave    bus
);

  typedef enum logic [1:0] {
    WIPE_ALL  = 2'd0,
    IDLE      = 2'd1,
    WIPE_BACK = 2'd2
  } state_t;

  localparam logic [X_W:0]       WIDTH_L  = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0]       HEIGHT_L = (Y_W+1)'(HEIGHT);
  localparam logic [Y_W-1:0]     LAST_ROW = Y_W'(HEIGHT-1);
  localparam logic [WIDTH-1:0]   MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] row,
                                                input logic [WIDTH-1:0] mask,
                                                input logic [1:0]       op);
    case (op)
      2'b00:   apply_op = row | mask;
      2'b01:   apply_op = row & ~mask;
      2'b10:   apply_op = row ^ mask;
      default: apply_op = row;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [Y_W-1:0]   row_q, row_d;
  logic             front_sel_q, front_sel_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] saida_x_q, saida_x_d;
  logic [Y_W-1:0]   saida_y_q, saida_y_d;

  logic [WIDTH-1:0] mem_q [2][HEIGHT];
  logic             mem_we    [2];
  logic [Y_W-1:0]   mem_row   [2];
  logic [WIDTH-1:0] mem_wdata [2];

  logic             back;
  logic             x_ok, y_ok, rd_ok, pix_ok;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    front_sel_d = front_sel_q;
    pending_d   = pending_q;
    for (int b = 0; b < 2; b++) begin
      mem_we[b]    = 1'b0;
      mem_row[b]   = row_q;
      mem_wdata[b] = '0;
    end

    back   = ~front_sel_q;
    x_ok   = {1'b0, bus.coor_x} < WIDTH_L;
    y_ok   = {1'b0, bus.coor_y} < HEIGHT_L;
    rd_ok  = {1'b0, bus.rd_y} < HEIGHT_L;
    pix_ok = bus.we && (bus.op != 2'b11) && x_ok && y_ok;

    // Read stage: front row is registered; blanked during the power-on wipe.
    saida_y_d = bus.rd_y;
    saida_x_d = '0;
    if (state_q != WIPE_ALL && rd_ok)
      saida_x_d = mem_q[front_sel_q][bus.rd_y];

    case (state_q)
      WIPE_ALL, WIPE_BACK: begin
        mem_we[back] = 1'b1;
        if (state_q == WIPE_ALL)
          mem_we[front_sel_q] = 1'b1;
        if (bus.swap)
          pending_d = 1'b1;
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = IDLE;
          // A swap requested at any time during the wipe runs on its final edge.
          if (pending_q || bus.swap) begin
            pending_d   = 1'b0;
            front_sel_d = ~front_sel_q;
            if (AUTO_WIPE)
              state_d = WIPE_BACK;
          end
        end
      end
      IDLE: begin
        if (pix_ok) begin
          mem_we[back]    = 1'b1;
          mem_row[back]   = bus.coor_y;
          mem_wdata[back] = apply_op(mem_q[back][bus.coor_y], MSB_MASK >> bus.coor_x, bus.op);
        end
        if (bus.swap) begin
          front_sel_d = ~front_sel_q;
          row_d       = '0;
          if (AUTO_WIPE)
            state_d = WIPE_BACK;
        end else if (bus.wipe) begin
          row_d   = '0;
          state_d = WIPE_BACK;
        end
      end
      default: begin
        state_d = WIPE_ALL;
        row_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= WIPE_ALL;
      row_q       <= '0;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b1;
      saida_x_q   <= '0;
      saida_y_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      saida_x_q   <= saida_x_d;
      saida_y_q   <= saida_y_d;
    end
  end

  // Storage: at most one row per buffer is written each cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!clear && mem_we[b])
        mem_q[b][mem_row[b]] <= mem_wdata[b];
    end
  end

  assign bus.saida_x   = saida_x_q;
  assign bus.saida_y   = saida_y_q;
  assign bus.busy      = busy_q;
  assign bus.front_sel = front_sel_q;

endmodule

// File: tb/tb_memoria_frame_dupla.sv
// Scoreboard bench for memoria_frame_dupla: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a frame-level reference model.
module tb_memoria_frame_dupla;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam bit AW = 1'b1;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  memoria_frame_dupla_if #(.WIDTH(W), .X_W(XW), .Y_W(YW)) bus ();

  memoria_frame_dupla #(
    .WIDTH(W), .HEIGHT(H), .X_W(XW), .Y_W(YW), .AUTO_WIPE(AW)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0]  x;
    logic [YW-1:0] y;
    logic          busy;
    logic          fs;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: two frames, displayed index, rows still to wipe, pending swap.
  logic [W-1:0] fb [2][H];
  int           rows_left = 0;
  int           wrow      = 0;
  bit           wipe_both = 1'b0;
  bit           fs        = 1'b0;
  bit           pend      = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input bit c, input bit we_i, input int op_i, input int x, input int y,
                      input bit sw, input bit wp, input int ry);
    exp_t e;
    @(negedge clk);
    clear      = c;
    bus.we     = we_i;
    bus.op     = 2'(op_i);
    bus.coor_x = XW'(x);
    bus.coor_y = YW'(y);
    bus.swap   = sw;
    bus.wipe   = wp;
    bus.rd_y   = YW'(ry);
    if (c) begin
      e.x = '0; e.y = '0;
      fs = 1'b0; pend = 1'b0; rows_left = H; wrow = 0; wipe_both = 1'b1;
    end else begin
      e.y = YW'(ry);
      e.x = '0;
      if (ry < H && !(rows_left > 0 && wipe_both))
        e.x = fb[fs][ry];
      if (rows_left > 0) begin
        fb[!fs][wrow] = '0;
        if (wipe_both) fb[fs][wrow] = '0;
        wrow++;
        rows_left--;
        if (sw) pend = 1'b1;
        if (rows_left == 0) begin
          wipe_both = 1'b0;
          if (pend) begin
            pend = 1'b0;
            fs   = !fs;
            if (AW) begin rows_left = H; wrow = 0; end
          end
        end
      end else begin
        if (we_i && op_i != 3 && x < W && y < H) begin
          case (op_i)
            0:       fb[!fs][y][W-1-x] = 1'b1;
            1:       fb[!fs][y][W-1-x] = 1'b0;
            default: fb[!fs][y][W-1-x] = ~fb[!fs][y][W-1-x];
          endcase
        end
        if (sw) begin
          fs = !fs;
          if (AW) begin rows_left = H; wrow = 0; end
        end else if (wp) begin
          rows_left = H; wrow = 0;
        end
      end
    end
    e.busy = (rows_left > 0);
    e.fs   = fs;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b0, i % 16);
  endtask

  task automatic wr(input int op_i, input int x, input int y);
    step(1'b0, 1'b1, op_i, x, y, 1'b0, 1'b0, 0);
  endtask

  task automatic do_swap();
    step(1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0, 0);
  endtask

  // Monitor: one expected response per clock, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        check("saida_x",   32'(bus.saida_x),   32'(me.x));
        check("saida_y",   32'(bus.saida_y),   32'(me.y));
        check("busy",      32'(bus.busy),      32'(me.busy));
        check("front_sel", 32'(bus.front_sel), 32'(me.fs));
      end
    end
  end

  initial begin
    bus.we = 1'b0; bus.op = 2'b11; bus.coor_x = '0; bus.coor_y = '0;
    bus.swap = 1'b0; bus.wipe = 1'b0; bus.rd_y = '0;

    step(1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b0, 0);
    idle(H + 20);

    // Corner pixels on one row, then swap and scan it.
    wr(0, 0, 3);
    wr(0, W-1, 3);
    do_swap();
    idle(H + 4);

    // Set/toggle interplay on row 2.
    wr(0, 5, 2);
    wr(2, 5, 2);
    wr(2, 6, 2);
    do_swap();
    idle(H + 4);

    // Dropped writes: x and y out of range, op=11.
    wr(0, 13, 0);
    wr(0, 0, 13);
    wr(3, 0, 0);
    step(1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b0, 14);
    do_swap();
    idle(H + 4);

    // Write and second swap while the back buffer is being wiped.
    wr(0, 4, 4);
    do_swap();
    idle(3);
    wr(0, 1, 1);
    do_swap();
    idle(2 * H + 4);

    // Swap and wipe together, then an explicit wipe.
    step(1'b0, 1'b1, 0, 2, 2, 1'b1, 1'b1, 2);
    idle(H + 2);
    step(1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b1, 0);
    idle(H + 2);

    // Clear in the middle of a back-buffer wipe.
    wr(0, 7, 7);
    do_swap();
    idle(7);
    step(1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b0, 0);
    idle(H + 16);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0,
           int'($urandom_range(0, 15)));
    end
    idle(4);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
